// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared select encodings, Tuse/Tnew constants and slot type for hazard_ctrl
package hazard_ctrl_pkg;

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    localparam logic [1:0] FWD_D_RF  = 2'b00;
    localparam logic [1:0] FWD_D_E   = 2'b01;
    localparam logic [1:0] FWD_D_M   = 2'b10;
    localparam logic [1:0] FWD_D_W   = 2'b11;

    localparam logic [1:0] FWD_E_ID  = 2'b00;
    localparam logic [1:0] FWD_E_EM  = 2'b01;
    localparam logic [1:0] FWD_E_MW  = 2'b10;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    function automatic logic reg_match(input logic [4:0] wa, input logic [4:0] a);
        return (a != 5'd0) && (wa == a);
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - mult/div busy window counter, loaded when a mult/div leaves D
module md_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic div,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - shadow E/M/W pipeline producing stall and forwarding selects for the ID stage
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       d_md_start,
    input  logic       d_md_div,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       fwd_rt_m,
    output logic       md_busy
);

    // Older stages keep only the fields that are still consulted there.
    slot_t      e_q, e_d;
    logic       e_md_q, e_md_d;
    logic [4:0] m_wa_q, m_wa_d, m_rt_q, m_rt_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_wa_q, w_wa_d;
    logic [1:0] w_tnew_q, w_tnew_d;

    logic stall_rs, stall_rt, stall_md;

    always_comb begin
        e_d      = stall ? BUBBLE : {d_wa, d_tnew, d_rs, d_rt};
        e_md_d   = stall ? 1'b0 : d_md_start;
        m_wa_d   = e_q.wa;
        m_tnew_d = sat_dec(e_q.tnew);
        m_rt_d   = e_q.rt;
        w_wa_d   = m_wa_q;
        w_tnew_d = sat_dec(m_tnew_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q      <= BUBBLE;
            e_md_q   <= 1'b0;
            m_wa_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            m_rt_q   <= 5'd0;
            w_wa_q   <= 5'd0;
            w_tnew_q <= 2'd0;
        end else begin
            e_q      <= e_d;
            e_md_q   <= e_md_d;
            m_wa_q   <= m_wa_d;
            m_tnew_q <= m_tnew_d;
            m_rt_q   <= m_rt_d;
            w_wa_q   <= w_wa_d;
            w_tnew_q <= w_tnew_d;
        end
    end

    always_comb begin
        stall_rs = (d_tuse_rs != TUSE_NONE) &&
                   ((reg_match(e_q.wa, d_rs) && (e_q.tnew > d_tuse_rs)) ||
                    (reg_match(m_wa_q, d_rs) && (m_tnew_q > d_tuse_rs)));
        stall_rt = (d_tuse_rt != TUSE_NONE) &&
                   ((reg_match(e_q.wa, d_rt) && (e_q.tnew > d_tuse_rt)) ||
                    (reg_match(m_wa_q, d_rt) && (m_tnew_q > d_tuse_rt)));
        stall_md = d_md_use && (md_busy || e_md_q);
        stall    = stall_rs || stall_rt || stall_md;
    end

    always_comb begin
        fwd_rs_d = FWD_D_RF;
        if (reg_match(e_q.wa, d_rs) && e_q.tnew == 2'd0)       fwd_rs_d = FWD_D_E;
        else if (reg_match(m_wa_q, d_rs) && m_tnew_q == 2'd0)  fwd_rs_d = FWD_D_M;
        else if (reg_match(w_wa_q, d_rs) && w_tnew_q == 2'd0)  fwd_rs_d = FWD_D_W;

        fwd_rt_d = FWD_D_RF;
        if (reg_match(e_q.wa, d_rt) && e_q.tnew == 2'd0)       fwd_rt_d = FWD_D_E;
        else if (reg_match(m_wa_q, d_rt) && m_tnew_q == 2'd0)  fwd_rt_d = FWD_D_M;
        else if (reg_match(w_wa_q, d_rt) && w_tnew_q == 2'd0)  fwd_rt_d = FWD_D_W;

        fwd_rs_e = FWD_E_ID;
        if (reg_match(m_wa_q, e_q.rs) && m_tnew_q == 2'd0)     fwd_rs_e = FWD_E_EM;
        else if (reg_match(w_wa_q, e_q.rs))                    fwd_rs_e = FWD_E_MW;

        fwd_rt_e = FWD_E_ID;
        if (reg_match(m_wa_q, e_q.rt) && m_tnew_q == 2'd0)     fwd_rt_e = FWD_E_EM;
        else if (reg_match(w_wa_q, e_q.rt))                    fwd_rt_e = FWD_E_MW;

        fwd_rt_m = reg_match(w_wa_q, m_rt_q);
    end

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_counter (
        .clk (clk),
        .rst (reset),
        .load(d_md_start && !stall),
        .div (d_md_div),
        .busy(md_busy)
    );

endmodule
